wrr_pkt_arbiter: RTL
====================

WRR_PKT_ARBITER -- requirements
Module: wrr_pkt_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, 16, number of write-source ports (2..32).
REQ-002 SHALL have parameter DATA_W, 256, beat width in bits.
REQ-003 SHALL have parameter PRIO_W, 3, per-port priority/weight field width.
REQ-004 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sp0_wrr1  input  1  mode: 0 strict priority, 1 weighted round robin.
REQ-007 SHALL have port ready  input  NUM_PORTS  per-port beat available.
REQ-008 SHALL have port eop  input  NUM_PORTS  per-port current beat is last of packet.
REQ-009 SHALL have port priority_in  input  NUM_PORTS*PRIO_W  packed; port j at [(j+1)*PRIO_W-1:j*PRIO_W].
REQ-010 SHALL have port data_in  input  NUM_PORTS*DATA_W  packed beats, same packing as priority_in.
REQ-011 SHALL have port in_ack  output  NUM_PORTS  one-hot combinational; beat of that port consumed this cycle.
REQ-012 SHALL have port data_out  output  DATA_W  registered selected beat.
REQ-013 SHALL have port out_valid  output  1  data_out holds a valid beat.
REQ-014 SHALL have port out_eop  output  1  data_out beat is last of packet.
REQ-015 SHALL have port out_ready  input  1  downstream accepts beat when out_valid high.
REQ-016 SHALL have port select  output  clog2(NUM_PORTS)  granted port index, registered.
REQ-017 SHALL have port transfering  output  1  a packet grant is held.

Function
REQ-018 SHALL use FSM states IDLE, XFER; grant locks to one port from grant until that port's eop beat is consumed.
REQ-019 In IDLE with >=1 eligible requester, SHALL register winner into select and enter XFER next cycle; transfering=1 exactly while in XFER.
REQ-020 In XFER, in_ack[select]=ready[select] && (!out_valid || out_ready); all other in_ack bits 0; in_ack=0 in IDLE.
REQ-021 On in_ack, SHALL load data_out/out_eop from port select and set out_valid next cycle (1-cycle latency).
REQ-022 out_valid && !out_ready SHALL hold data_out/out_eop stable; out_valid clears after acceptance with no new ack.
REQ-023 On ack of a beat with eop[select]=1, SHALL return to IDLE; next grant no earlier than cycle after (one-cycle gap min).
REQ-024 SP mode: winner = highest priority_in among ready ports; ties broken round-robin starting at last_grant+1, wrapping at NUM_PORTS-1 -> 0.
REQ-025 WRR mode: each port has credit counter (PRIO_W+1 bits); eligible = ready && credit>0; winner = first eligible scanning from last_grant+1 with wrap.
REQ-026 WRR: credit of granted port SHALL decrement by 1 at packet end (eop ack), never below 0.
REQ-027 WRR: in IDLE, if requesters exist but none eligible, SHALL reload every credit to priority_in+1 that cycle and arbitrate next cycle.
REQ-028 sp0_wrr1 SHALL be sampled only in IDLE; change mid-packet has no effect until packet end; SP->WRR switch reloads all credits.
REQ-029 ready[select] dropping mid-packet SHALL stall (no ack), grant retained; no timeout.
REQ-030 Simultaneous downstream accept and new ack SHALL replace data_out with no bubble (full throughput 1 beat/cycle).

Reset
REQ-031 rst low SHALL asynchronously force: state IDLE, select 0, last_grant NUM_PORTS-1, transfering 0, out_valid 0, out_eop 0, data_out 0, credits priority-independent 0 (reload on first WRR arbitration).
REQ-032 Reset mid-packet SHALL abandon the packet; partial beat in data_out discarded; in_ack 0 during reset.

Structure
REQ-033 SHALL place state enum, mode constants (MODE_SP=0, MODE_WRR=1) and index-width function in shared package arb_pkg.
REQ-034 SHALL implement masked rotating priority encoder as sub-module rr_pick (inputs request vector, start pointer; outputs index, found), used by both modes.

Verification
REQ-035 SP: ready=0x0013, prio p0=2,p1=5,p4=5; single-beat packets -> grants 1,4,1,4 while requests persist; p0 starved.
REQ-036 WRR: ready=0x0007, prio 0,1,2, all continuous 1-beat packets -> per round grants p0 x1, p1 x2, p2 x3, reload cycle between rounds.
REQ-037 Backpressure: 4-beat packet port 3, out_ready low 3 cycles at beat 2 -> data_out constant, in_ack 0 those cycles, all 4 beats delivered in order, out_eop on beat 4 only.
REQ-038 Lock: port 2 granted, port 9 higher priority asserts mid-packet -> select stays 2 until eop ack, then 9.
REQ-039 Reset: assert rst low during beat 2 of packet -> out_valid, transfering, select 0 immediately; after release grant restarts from port 0 scan.
REQ-040 Wrap: last_grant=15, ready=0x8001 equal prio SP -> grant 0 then 15.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the packet arbiter: FSM states, mode encodings and
// the select-index width helper.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam logic MODE_SP  = 1'b0;
  localparam logic MODE_WRR = 1'b1;

  // Width of a port index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request found when
// scanning upward from start, wrapping from NUM_PORTS-1 back to 0.
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int SEL_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     start,
  output logic [SEL_W-1:0]     idx,
  output logic                 found
);

  // first-hit scan; the wrap is a conditional subtract so no divider is built
  always_comb begin
    int k;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = int'(start) + i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Packet-locked arbiter with strict-priority or weighted-round-robin choice.
// One output register stage; a grant is held until the granted port's eop
// beat has been consumed.
//
//   state | meaning
//   IDLE  | no grant held; arbitrate, or reload WRR credits
//   XFER  | grant held on port 'select'; beats move on in_ack
module wrr_pkt_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 256,
  parameter int PRIO_W    = 3,
  localparam int SEL_W    = idx_w(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sp0_wrr1,
  input  logic [NUM_PORTS-1:0]          ready,
  input  logic [NUM_PORTS-1:0]          eop,
  input  logic [NUM_PORTS*PRIO_W-1:0]   priority_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   data_in,
  output logic [NUM_PORTS-1:0]          in_ack,
  output logic [DATA_W-1:0]             data_out,
  output logic                          out_valid,
  output logic                          out_eop,
  input  logic                          out_ready,
  output logic [SEL_W-1:0]              select,
  output logic                          transfering
);

  arb_state_t           state_q, state_d;
  logic                 mode_q;
  logic [SEL_W-1:0]     last_grant_q, start_ptr, pick_idx;
  logic                 pick_found;
  logic [PRIO_W:0]      credit_q [NUM_PORTS];
  logic [PRIO_W-1:0]    prio [NUM_PORTS];
  logic [PRIO_W-1:0]    max_prio;
  logic [NUM_PORTS-1:0] sp_req, wrr_elig, pick_req;
  logic                 reload_all, grant, ack_ok, pkt_end;

  // unpack priorities and build the request vector for each mode
  always_comb begin
    max_prio = '0;
    sp_req   = '0;
    wrr_elig = '0;
    for (int j = 0; j < NUM_PORTS; j++) prio[j] = priority_in[j*PRIO_W +: PRIO_W];
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (ready[j] && (prio[j] > max_prio)) max_prio = prio[j];
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      sp_req[j]   = ready[j] && (prio[j] == max_prio);
      wrr_elig[j] = ready[j] && (credit_q[j] != '0);
    end
  end

  assign start_ptr = (last_grant_q == SEL_W'(NUM_PORTS-1)) ? '0 : last_grant_q + 1'b1;
  assign pick_req  = (sp0_wrr1 == MODE_WRR) ? wrr_elig : sp_req;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W)
  ) u_pick (
    .req   (pick_req),
    .start (start_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // next state, grant/reload decision and the combinational beat ack
  always_comb begin
    state_d    = state_q;
    reload_all = 1'b0;
    grant      = 1'b0;
    ack_ok     = 1'b0;
    in_ack     = '0;
    case (state_q)
      IDLE: begin
        // entering WRR from SP, or all WRR requesters out of credit
        reload_all = (sp0_wrr1 == MODE_WRR) &&
                     ((mode_q == MODE_SP) || ((|ready) && !(|wrr_elig)));
        grant = !reload_all && pick_found;
        if (grant) state_d = XFER;
      end
      XFER: begin
        ack_ok = ready[select] && (!out_valid || out_ready);
        if (ack_ok) begin
          in_ack[select] = 1'b1;
          if (eop[select]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pkt_end     = ack_ok && eop[select];
  assign transfering = (state_q == XFER);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // grant bookkeeping; mode is only observed while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      select       <= '0;
      last_grant_q <= SEL_W'(NUM_PORTS-1);
      mode_q       <= MODE_SP;
    end else if (state_q == IDLE) begin
      mode_q <= sp0_wrr1;
      if (grant) begin
        select       <= pick_idx;
        last_grant_q <= pick_idx;
      end
    end
  end

  // WRR credits: bulk reload, or one spent per completed packet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NUM_PORTS; j++) credit_q[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (reload_all)
          credit_q[j] <= (PRIO_W+1)'(prio[j]) + (PRIO_W+1)'(1);
        else if (pkt_end && (mode_q == MODE_WRR) && (select == SEL_W'(j)) && (credit_q[j] != '0))
          credit_q[j] <= credit_q[j] - (PRIO_W+1)'(1);
      end
    end
  end

  // output beat register; a new ack may replace an accepted beat in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      out_eop   <= 1'b0;
      out_valid <= 1'b0;
    end else if (ack_ok) begin
      data_out  <= data_in[select*DATA_W +: DATA_W];
      out_eop   <= eop[select];
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
